// File: rtl/qr_acc_bitserial_mac.sv
// Bit-serial MAC sequencer for the analog QR array: drives one activation bit-plane
// per DRIVE/CAPTURE pair (MSB first) and shift-accumulates the encoded ADC codes per lane.
module qr_acc_bitserial_mac #(
    parameter int numRows        = 128,
    parameter int outputElements = 128,
    parameter int numAdcBits     = 4,
    parameter int inBits         = 4,
    parameter int accBits        = numAdcBits + inBits
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic                                   signed_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [numRows*inBits-1:0]              in_data_i,
    output logic [numRows-1:0]                     data_p_o,
    output logic [numRows-1:0]                     data_n_o,
    output logic                                   mac_en_o,
    input  logic [outputElements*(2**numAdcBits-1)-1:0] adc_therm_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [outputElements*accBits-1:0]      out_data_o,
    output logic                                   busy_o
);

    localparam int compCount = 2**numAdcBits - 1;
    localparam int planeBits = (inBits > 1) ? $clog2(inBits) : 1;
    localparam logic [planeBits-1:0] PLANE_TOP = planeBits'(inBits - 1);
    localparam logic [accBits-1:0]   ADC_BIAS  = accBits'(2**(numAdcBits - 1));

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                              state_r, state_s;
    logic [planeBits-1:0]                plane_r, plane_s;
    logic                                load_s;
    logic [numRows*inBits-1:0]           act_r, act_s;
    logic                                signed_r, signed_s;
    logic [numRows-1:0]                  data_p_r, data_p_s;
    logic                                mac_en_r, out_valid_r, busy_r;
    logic [outputElements*accBits-1:0]   acc_r, acc_s, out_data_r;

    // Thermometer count: highest set comparator wins, bubbles below it are ignored.
    function automatic logic [numAdcBits-1:0] therm_count(input logic [compCount-1:0] therm);
        logic [numAdcBits-1:0] n;
        n = {numAdcBits{1'b0}};
        for (int i = 0; i < compCount; i++) begin
            if (therm[i]) begin
                n = numAdcBits'(i + 1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    assign in_ready_o = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready_i);
    assign load_s     = in_valid_i && in_ready_o;

    // Next-state and plane-counter logic.
    always_comb begin
        state_s = state_r;
        plane_s = plane_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_s = ST_DRIVE;
                    plane_s = PLANE_TOP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (plane_r == {planeBits{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRIVE;
                    plane_s = plane_r - planeBits'(1);
                end
            end
            ST_DONE: begin
                if (load_s) begin
                    state_s = ST_DRIVE;
                    plane_s = PLANE_TOP;
                end else if (out_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                plane_s = {planeBits{1'b0}};
            end
        endcase
    end

    // Latched activations and the row selects for the upcoming cycle.
    always_comb begin : sel_comb
        logic [inBits-1:0] row_bits;
        row_bits = {inBits{1'b0}};
        if (load_s) begin
            act_s    = in_data_i;
            signed_s = signed_i;
        end else begin
            act_s    = act_r;
            signed_s = signed_r;
        end
        data_p_s = {numRows{1'b0}};
        if ((state_s == ST_DRIVE) || (state_s == ST_CAPTURE)) begin
            for (int r = 0; r < numRows; r++) begin
                row_bits    = act_s[r*inBits +: inBits];
                data_p_s[r] = row_bits[plane_s];
            end
        end else begin
            data_p_s = {numRows{1'b0}};
        end
    end

    // Per-lane encode and shift-accumulate; the MSB plane is negated for signed vectors.
    always_comb begin : acc_comb
        logic [numAdcBits-1:0] n_v;
        logic [accBits-1:0]    v_v;
        logic [accBits-1:0]    term_v;
        n_v    = {numAdcBits{1'b0}};
        v_v    = {accBits{1'b0}};
        term_v = {accBits{1'b0}};
        acc_s  = acc_r;
        for (int l = 0; l < outputElements; l++) begin
            n_v = therm_count(adc_therm_i[l*compCount +: compCount]);
            v_v = accBits'(n_v) - ADC_BIAS;
            if (signed_r && (plane_r == PLANE_TOP)) begin
                term_v = ~v_v + accBits'(1);
            end else begin
                term_v = v_v;
            end
            acc_s[l*accBits +: accBits] = {acc_r[l*accBits +: accBits-1], 1'b0} + term_v;
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= ST_IDLE;
            plane_r     <= {planeBits{1'b0}};
            act_r       <= {(numRows*inBits){1'b0}};
            signed_r    <= 1'b0;
            acc_r       <= {(outputElements*accBits){1'b0}};
            out_data_r  <= {(outputElements*accBits){1'b0}};
            data_p_r    <= {numRows{1'b0}};
            mac_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            plane_r     <= plane_s;
            act_r       <= act_s;
            signed_r    <= signed_s;
            data_p_r    <= data_p_s;
            mac_en_r    <= (state_s == ST_DRIVE);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
            if (load_s) begin
                acc_r <= {(outputElements*accBits){1'b0}};
            end else if (state_r == ST_CAPTURE) begin
                acc_r <= acc_s;
            end else begin
                acc_r <= acc_r;
            end
            if ((state_r == ST_CAPTURE) && (plane_r == {planeBits{1'b0}})) begin
                out_data_r <= acc_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign data_p_o    = data_p_r;
    assign data_n_o    = {numRows{1'b0}};
    assign mac_en_o    = mac_en_r;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_qr_acc_bitserial_mac.sv
// Self-checking bench for qr_acc_bitserial_mac: an ADC model answers each DRIVE strobe and
// results are compared against a sum-of-weighted-planes reference.
module tb_qr_acc_bitserial_mac;

    localparam int NR = 128;
    localparam int OE = 128;
    localparam int NAB = 4;
    localparam int CC = 15;
    localparam int IB = 4;
    localparam int AB = 8;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    logic signed_i = 1'b0;
    logic in_valid_i = 1'b0;
    logic out_ready_i = 1'b0;
    logic in_ready_o, mac_en_o, out_valid_o, busy_o;
    logic [NR*IB-1:0] in_data_i = '0;
    logic [NR-1:0] data_p_o, data_n_o;
    logic [OE*CC-1:0] adc_therm_i = '0;
    logic [OE*AB-1:0] out_data_o;

    int n_chk = 0;
    int n_fail = 0;
    logic [CC-1:0] adc_tab [IB][OE];
    logic [NR*IB-1:0] cur_act;
    logic cur_sgn;

    qr_acc_bitserial_mac dut (
        .clk(clk), .nrst(nrst), .signed_i(signed_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_data_i(in_data_i), .data_p_o(data_p_o),
        .data_n_o(data_n_o), .mac_en_o(mac_en_o), .adc_therm_i(adc_therm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ADC code value: (top set comparator index + 1) minus mid-scale
    function automatic int adc_value(input logic [CC-1:0] t);
        int n;
        n = 0;
        for (int i = 0; i < CC; i++) if (t[i]) n = i + 1;
        return n - (1 << (NAB - 1));
    endfunction

    // Reference result: sum over planes of weight * ADC value * 2^plane
    function automatic int model_lane(input int l);
        int r, w;
        r = 0;
        for (int p = 0; p < IB; p++) begin
            w = (cur_sgn && p == IB - 1) ? -1 : 1;
            r += w * adc_value(adc_tab[p][l]) * (1 << p);
        end
        return r;
    endfunction

    function automatic logic [NR-1:0] plane_bits(input int p);
        logic [NR-1:0] b;
        for (int r = 0; r < NR; r++) b[r] = cur_act[r*IB + p];
        return b;
    endfunction

    function automatic logic [NR*IB-1:0] rand_act();
        logic [NR*IB-1:0] a;
        for (int k = 0; k < NR*IB/32; k++) a[k*32 +: 32] = $urandom;
        return a;
    endfunction

    task automatic fill_adc_all(input logic [CC-1:0] w3, input logic [CC-1:0] w2,
                                input logic [CC-1:0] w1, input logic [CC-1:0] w0);
        for (int l = 0; l < OE; l++) begin
            adc_tab[3][l] = w3; adc_tab[2][l] = w2; adc_tab[1][l] = w1; adc_tab[0][l] = w0;
        end
    endtask

    task automatic fill_adc_rand();
        for (int p = 0; p < IB; p++)
            for (int l = 0; l < OE; l++) adc_tab[p][l] = CC'($urandom_range(0, 32767));
    endtask

    // Starts at a negedge with the DUT in IDLE or DONE; ends at the negedge where DONE shows
    task automatic run_vector(input string name, input logic [NR*IB-1:0] act, input logic sgn);
        int p;
        logic [NR-1:0] exp_p;
        logic exp_en, exp_v;
        int got;
        cur_act = act; cur_sgn = sgn;
        in_data_i = act; signed_i = sgn; in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1;
        n_chk++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL %s accept_ready: got %b want 1", name, in_ready_o);
        end
        @(negedge clk);
        in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = rand_act(); signed_i = ~sgn;
        for (int c = 1; c <= 2*IB + 1; c++) begin
            if (c > 1) @(negedge clk);
            p = IB - 1 - (c - 1) / 2;
            if (c <= 2*IB) begin
                exp_p = plane_bits(p); exp_en = (c % 2 == 1); exp_v = 1'b0;
            end else begin
                exp_p = '0; exp_en = 1'b0; exp_v = 1'b1;
            end
            n_chk++;
            if (data_p_o !== exp_p) begin
                n_fail++; $display("FAIL %s data_p cyc%0d: got %h want %h", name, c, data_p_o, exp_p);
            end
            n_chk++;
            if (mac_en_o !== exp_en) begin
                n_fail++; $display("FAIL %s mac_en cyc%0d: got %b want %b", name, c, mac_en_o, exp_en);
            end
            n_chk++;
            if (out_valid_o !== exp_v) begin
                n_fail++; $display("FAIL %s out_valid cyc%0d: got %b want %b", name, c, out_valid_o, exp_v);
            end
            n_chk++;
            if (data_n_o !== '0 || busy_o !== 1'b1) begin
                n_fail++; $display("FAIL %s data_n/busy cyc%0d: got %h/%b want 0/1", name, c, data_n_o, busy_o);
            end
            if (c <= 2*IB && c % 2 == 1)
                for (int l = 0; l < OE; l++) adc_therm_i[l*CC +: CC] = adc_tab[p][l];
        end
        for (int l = 0; l < OE; l++) begin
            got = int'($signed(out_data_o[l*AB +: AB]));
            n_chk++;
            if (got !== model_lane(l)) begin
                n_fail++; $display("FAIL %s lane%0d: got %0d want %0d", name, l, got, model_lane(l));
            end
        end
    endtask

    task automatic retire(input string name);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        n_chk++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s retire: busy=%b valid=%b ready=%b want 0/0/1", name, busy_o, out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset();
        #1 nrst = 1'b0;
        #1;
        n_chk++;
        if (data_p_o !== '0 || mac_en_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== '0
            || busy_o !== 1'b0 || in_ready_o !== 1'b1 || data_n_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b en=%b busy=%b ready=%b", out_valid_o, mac_en_o, busy_o, in_ready_o);
        end
        @(negedge clk); @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        fill_adc_all(15'h7FFF, 15'h0000, 15'h01FF, 15'h00FF);
        run_vector("unsigned", rand_act(), 1'b0);
        retire("unsigned");
    endtask

    task automatic test_signed();
        fill_adc_all(15'h7FFF, 15'h0000, 15'h01FF, 15'h00FF);
        run_vector("signed", rand_act(), 1'b1);
        retire("signed");
    endtask

    task automatic test_bubble();
        fill_adc_all(15'h0101, 15'h0101, 15'h0101, 15'h0101);
        run_vector("bubble", rand_act(), 1'b0);
        retire("bubble");
        fill_adc_all(15'h0000, 15'h0000, 15'h0000, 15'h0000);
        run_vector("all_zero", rand_act(), 1'b0);
        retire("all_zero");
    endtask

    task automatic test_lanes();
        fill_adc_rand();
        for (int p = 0; p < IB; p++) begin
            adc_tab[p][0] = 15'h7FFF;
            adc_tab[p][OE-1] = 15'h0000;
        end
        run_vector("lanes", rand_act(), 1'b0);
        retire("lanes");
    endtask

    task automatic test_back_to_back();
        logic [OE*AB-1:0] snap;
        fill_adc_rand();
        run_vector("bp_first", rand_act(), 1'b1);
        snap = out_data_o;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid_o !== 1'b1 || out_data_o !== snap) begin
                n_fail++; $display("FAIL backpressure hold%0d: valid=%b data_changed=%b", k, out_valid_o, out_data_o !== snap);
            end
        end
        fill_adc_rand();
        run_vector("bp_second", rand_act(), 1'b0);
        retire("bp_second");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            fill_adc_rand();
            run_vector("random", rand_act(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) retire("random");
        end
        retire("random_end");
    endtask

    task automatic test_reset_mid_run();
        fill_adc_rand();
        cur_act = rand_act();
        in_data_i = cur_act; signed_i = 1'b0; in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        n_chk++;
        if (mac_en_o !== 1'b1) begin
            n_fail++; $display("FAIL midreset in_drive: mac_en got %b want 1", mac_en_o);
        end
        nrst = 1'b0;
        #1;
        n_chk++;
        if (data_p_o !== '0 || mac_en_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== '0
            || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset outputs: en=%b valid=%b busy=%b ready=%b", mac_en_o, out_valid_o, busy_o, in_ready_o);
        end
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL midreset aborted%0d: valid=%b ready=%b busy=%b", k, out_valid_o, in_ready_o, busy_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_bubble();
        test_lanes();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        fill_adc_all(15'h7FFF, 15'h0000, 15'h01FF, 15'h00FF);
        run_vector("after_reset", rand_act(), 1'b1);
        retire("after_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
